// File: rtl/telemetry_rx.sv
// telemetry_rx: receive end of the serial telemetry link.
// A UART_rx deserialises 8N1 bytes from RX. A frame is six bytes with no
// header: {0,batt_v[11:8]}, batt_v[7:0], {0,avg_curr[11:8]}, avg_curr[7:0],
// {0,avg_torque[11:8]}, avg_torque[7:0]. The block aligns on the idle gap
// between frames and publishes all three values together on a good frame.
//
// Handshake: the UART raises rdy for a received byte and holds it until
// clr_rdy; clr_rdy is tied to rdy, so every byte is consumed in the cycle it
// is first seen and rdy is effectively a one-cycle strobe.

module UART_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy
);
    localparam int CW   = $clog2(BAUD_DIV);
    localparam int HALF = BAUD_DIV / 2;

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;

    u_state_t        r_state;
    u_state_t        w_state_nxt;
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rdy;
    logic            w_half;
    logic            w_full;
    logic            w_cnt_clr;

    assign w_half  = (r_cnt == CW'(HALF - 1));
    assign w_full  = (r_cnt == CW'(BAUD_DIV - 1));
    assign rx_data = r_rx_data;
    assign rdy     = r_rdy;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // UART state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= U_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: start edge, mid-start check, eight data bits, stop bit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        case (r_state)
            U_IDLE:  if (!r_rx_s2) w_state_nxt = U_START;
            U_START: if (w_half) w_state_nxt = r_rx_s2 ? U_IDLE : U_DATA;
            U_DATA:  if (w_full && (r_bit_idx == 3'd7)) w_state_nxt = U_STOP;
            U_STOP:  if (w_full) w_state_nxt = U_IDLE;
            default: w_state_nxt = U_IDLE;
        endcase
        if ((w_state_nxt != r_state) || ((r_state == U_DATA) && w_full))
            w_cnt_clr = 1'b1;
    end

    // Bit timing counter, data shift register and the rdy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_rdy     <= 1'b0;
        end else begin
            if (w_cnt_clr || (r_state == U_IDLE)) r_cnt <= '0;
            else                                  r_cnt <= r_cnt + 1'b1;

            if (r_state == U_START) r_bit_idx <= '0;
            else if ((r_state == U_DATA) && w_full) begin
                r_shift   <= {r_rx_s2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // A low stop bit is a framing error: the byte is dropped.
            if ((r_state == U_STOP) && w_full && r_rx_s2) begin
                r_rdy     <= 1'b1;
                r_rx_data <= r_shift;
            end else if (clr_rdy) begin
                r_rdy <= 1'b0;
            end
        end
    end
endmodule

module telemetry_rx #(
    parameter int GAP_CYCLES = 65536,
    parameter int CNT_W      = 17,
    parameter int BAUD_DIV   = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        vld,
    output logic        frm_err
);
    typedef enum logic [2:0] {S_SYNC, S_B0, S_B1, S_B2, S_B3, S_B4, S_B5} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       w_rx_data;
    logic             w_rdy;
    logic             w_gap;
    logic             w_vld_nxt;
    logic             w_err_nxt;
    logic             w_nib_bad;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [3:0]       r_sh_b_hi;
    logic [7:0]       r_sh_b_lo;
    logic [3:0]       r_sh_c_hi;
    logic [7:0]       r_sh_c_lo;
    logic [3:0]       r_sh_t_hi;
    logic [11:0]      r_batt_v;
    logic [11:0]      r_avg_curr;
    logic [11:0]      r_avg_torque;
    logic             r_vld;
    logic             r_frm_err;

    UART_rx #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_data (w_rx_data),
        .rdy     (w_rdy),
        .clr_rdy (w_rdy)
    );

    assign w_gap      = (r_gap_cnt == CNT_W'(GAP_CYCLES));
    assign w_nib_bad  = (w_rx_data[7:4] != 4'h0);
    assign batt_v     = r_batt_v;
    assign avg_curr   = r_avg_curr;
    assign avg_torque = r_avg_torque;
    assign vld        = r_vld;
    assign frm_err    = r_frm_err;

    // Idle counter between received bytes, saturating at the gap threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_gap_cnt <= '0;
        else if (w_rdy)  r_gap_cnt <= '0;
        else if (!w_gap) r_gap_cnt <= r_gap_cnt + 1'b1;
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_SYNC;
        else        r_state <= w_state_nxt;
    end

    // Next state and the vld / frm_err strobes; a byte always wins over the gap.
    always_comb begin
        w_state_nxt = r_state;
        w_vld_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_SYNC: if (!w_rdy && w_gap) w_state_nxt = S_B0;
            S_B0: begin
                if (w_rdy) begin
                    if (w_nib_bad) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_state_nxt = S_B1;
                    end
                end
            end
            S_B2, S_B4: begin
                if (w_rdy) begin
                    if (w_nib_bad) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_state_nxt = (r_state == S_B2) ? S_B3 : S_B5;
                    end
                end else if (w_gap) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_B0;
                end
            end
            S_B1, S_B3: begin
                if (w_rdy) begin
                    w_state_nxt = (r_state == S_B1) ? S_B2 : S_B4;
                end else if (w_gap) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_B0;
                end
            end
            S_B5: begin
                if (w_rdy) begin
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_B0;
                end else if (w_gap) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_B0;
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    // Shadow capture per byte; the last byte publishes all three values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_b_hi    <= '0;
            r_sh_b_lo    <= '0;
            r_sh_c_hi    <= '0;
            r_sh_c_lo    <= '0;
            r_sh_t_hi    <= '0;
            r_batt_v     <= '0;
            r_avg_curr   <= '0;
            r_avg_torque <= '0;
            r_vld        <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_vld     <= w_vld_nxt;
            r_frm_err <= w_err_nxt;
            if (w_rdy) begin
                case (r_state)
                    S_B0: if (!w_nib_bad) r_sh_b_hi <= w_rx_data[3:0];
                    S_B1: r_sh_b_lo <= w_rx_data;
                    S_B2: if (!w_nib_bad) r_sh_c_hi <= w_rx_data[3:0];
                    S_B3: r_sh_c_lo <= w_rx_data;
                    S_B4: if (!w_nib_bad) r_sh_t_hi <= w_rx_data[3:0];
                    S_B5: begin
                        r_batt_v     <= {r_sh_b_hi, r_sh_b_lo};
                        r_avg_curr   <= {r_sh_c_hi, r_sh_c_lo};
                        r_avg_torque <= {r_sh_t_hi, w_rx_data};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: serial driver, byte-level reference model feeding an
// expected-event queue, and a monitor that pops on every vld / frm_err strobe.
module tb_telemetry_rx;
  localparam int BAUD = 8;
  localparam int GAP  = 300;
  localparam int CW   = 9;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic [11:0] batt_v;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic        vld;
  logic        frm_err;

  int checks   = 0;
  int failures = 0;

  // expected event: {is_vld, batt_v, avg_curr, avg_torque}
  logic [36:0] exp_q[$];
  logic [36:0] mon_got;
  logic [36:0] mon_exp;

  // reference model state
  bit          m_synced;
  int          m_idx;
  logic [7:0]  m_bytes[6];
  logic [11:0] m_b;
  logic [11:0] m_c;
  logic [11:0] m_t;
  logic [7:0]  fr[6];

  telemetry_rx #(.GAP_CYCLES(GAP), .CNT_W(CW), .BAUD_DIV(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .batt_v     (batt_v),
    .avg_curr   (avg_curr),
    .avg_torque (avg_torque),
    .vld        (vld),
    .frm_err    (frm_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_synced = 1'b0;
    m_idx    = 0;
    m_b      = '0;
    m_c      = '0;
    m_t      = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_synced) return;
    if ((m_idx % 2 == 0) && (b[7:4] != 4'h0)) begin
      exp_q.push_back({1'b0, m_b, m_c, m_t});
      m_synced = 1'b0;
      m_idx    = 0;
      return;
    end
    m_bytes[m_idx] = b;
    m_idx++;
    if (m_idx == 6) begin
      m_b   = {m_bytes[0][3:0], m_bytes[1]};
      m_c   = {m_bytes[2][3:0], m_bytes[3]};
      m_t   = {m_bytes[4][3:0], m_bytes[5]};
      m_idx = 0;
      exp_q.push_back({1'b1, m_b, m_c, m_t});
    end
  endtask

  task automatic model_gap();
    if (!m_synced) begin
      m_synced = 1'b1;
      m_idx    = 0;
    end else if (m_idx > 0) begin
      exp_q.push_back({1'b0, m_b, m_c, m_t});
      m_idx = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v);
    RX = v;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
  endtask

  task automatic idle_clks(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // idle long enough that the DUT sees a gap, and tell the model
  task automatic do_gap(input int extra);
    model_gap();
    idle_clks(GAP + extra);
  endtask

  task automatic set_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    fr[0] = {4'h0, b[11:8]};
    fr[1] = b[7:0];
    fr[2] = {4'h0, c[11:8]};
    fr[3] = c[7:0];
    fr[4] = {4'h0, t[11:8]};
    fr[5] = t[7:0];
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_byte(fr[i]);
  endtask

  task automatic check_outputs(input string name);
    checks++;
    if ({batt_v, avg_curr, avg_torque} !== {m_b, m_c, m_t}) begin
      failures++;
      $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", name,
               batt_v, avg_curr, avg_torque, m_b, m_c, m_t);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && (vld || frm_err)) begin
      checks++;
      mon_got = {vld, batt_v, avg_curr, avg_torque};
      if (vld && frm_err) begin
        failures++;
        $display("FAIL both_strobes: vld=1 frm_err=1 at %0t, expected only one", $time);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got vld=%b out=%h/%h/%h, expected no event",
                 vld, batt_v, avg_curr, avg_torque);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL event: got vld=%b %h/%h/%h expected vld=%b %h/%h/%h",
                   mon_got[36], mon_got[35:24], mon_got[23:12], mon_got[11:0],
                   mon_exp[36], mon_exp[35:24], mon_exp[23:12], mon_exp[11:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(900_000);
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] rb;
    RX    = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_outputs("reset_outputs");
    checks++;
    if (vld !== 1'b0 || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: got vld=%b frm_err=%b expected 0/0", vld, frm_err);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 1: first frame after a gap; outputs stay 0 until the last byte
    do_gap(20);
    set_frame(12'hABC, 12'h123, 12'h7FF);
    send_frame(5);
    check_outputs("before_byte5");
    send_byte(fr[5]);
    idle_clks(20);
    check_outputs("frame1");

    // 2: two back-to-back frames
    set_frame(12'hABC, 12'h123, 12'h7FF);
    send_frame(6);
    set_frame(12'h001, 12'hFFE, 12'h800);
    send_frame(6);
    idle_clks(20);
    check_outputs("back_to_back");

    // 3: bad nibble on the third byte, then a clean frame after a gap
    do_gap(20);
    send_byte(8'h0A);
    send_byte(8'hBC);
    send_byte(8'hF1);
    idle_clks(20);
    check_outputs("bad_nibble_hold");
    do_gap(20);
    set_frame(12'h5A5, 12'h0F0, 12'h3C3);
    send_frame(6);

    // 4: three bytes then a timeout; next frame decodes without resync
    set_frame(12'h111, 12'h222, 12'h333);
    send_frame(3);
    do_gap(20);
    check_outputs("timeout_hold");
    set_frame(12'h9E7, 12'h456, 12'h0C1);
    send_frame(6);

    // 5: reset during byte 3
    set_frame(12'hDEA, 12'hBEE, 12'hF00);
    send_frame(3);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(fr[3][i]);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset_midframe");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 3; i < 8; i++) drive_bit(fr[3][i]);
    drive_bit(1'b1);
    send_byte(fr[4]);
    send_byte(fr[5]);
    do_gap(20 * BAUD);
    set_frame(12'h246, 12'h8AC, 12'hE02);
    send_frame(6);

    // 6: byte 3 rdy lands in the same cycle the gap counter saturates
    set_frame(12'h135, 12'h79B, 12'hDF1);
    send_frame(3);
    idle_clks(GAP + 1 - 10 * BAUD);
    send_frame_from3();
    idle_clks(20);
    check_outputs("rdy_gap_tie");

    // randomized mix of gaps, clean frames, partial frames and bad nibbles
    for (int it = 0; it < 28; it++) begin
      if ($urandom_range(0, 9) < 7) do_gap($urandom_range(5, 60));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 6;
      for (int k = 0; k < n; k++) begin
        rb = 8'($urandom_range(0, 255));
        if ((k % 2 == 0) && ($urandom_range(0, 9) != 0)) rb[7:4] = 4'h0;
        send_byte(rb);
      end
    end
    do_gap(50);
    idle_clks(20);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d unobserved expected events, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic send_frame_from3();
    for (int i = 3; i < 6; i++) send_byte(fr[i]);
  endtask
endmodule
